i2c_master_fsm: RTL and testbench
=================================

Name: i2c_master_fsm

Overview:
- Single-byte I2C bus initiator: the master end of the bus that our address-translator responder answers.
- Generates START, 7-bit address + R/W, one data byte (write or read), ACK/NACK handling and STOP on open-drain SDA/SCL.
- Sits between a host-side request/response handshake and the board-level I2C pins.
- Synchronous to clk; supports slave clock stretching.

Parameters:
- CLK_DIV, 125, clk cycles per quarter SCL bit period (125 at 50 MHz gives 100 kHz); legal range 2..65535.

Ports:
- clk  input  1  system clock
- reset  input  1  reset
- start  input  1  request a transaction; sampled only when busy=0
- rw  input  1  0 = write, 1 = read; latched on accepted start
- slave_addr  input  7  target address; latched on accepted start
- wr_data  input  8  write byte; latched on accepted start
- rd_data  output  8  byte read from slave; valid when done=1 and rw was 1
- busy  output  1  high from accepted start until done
- done  output  1  one-clk pulse at transaction end
- ack_err  output  1  valid with done; 1 = address or write-data NACK
- scl  inout  1  open-drain I2C clock (drive 0 or Z)
- sda  inout  1  open-drain I2C data (drive 0 or Z)

Behaviour:
- Reset is asynchronous, active-high. Reset values: busy=0, done=0, ack_err=0, rd_data=0x00, scl=Z, sda=Z, state=IDLE, tick counter=0.
- Reset mid-operation releases both lines immediately and returns to IDLE. No bus-recovery sequence is issued.
- Tick generator counts 0..CLK_DIV-1; a qtick pulses for one clk on wrap. The counter runs only while busy=1 and restarts at 0 on an accepted start.
- Each bit is 4 quarters:
  - Q0: SCL low; set SDA (drive 0 for a 0 bit, release for a 1 bit).
  - Q1: release SCL.
  - Q2: SCL high; sample SDA at the qtick ending Q2.
  - Q3: drive SCL low.
- Clock stretching: in Q1, if SCL reads 0 after release, the tick counter holds until SCL reads 1. Stretch time does not count toward Q1.
- Start acceptance: start=1 while busy=0 latches {slave_addr, rw}, wr_data, clears ack_err, and sets busy on the next clk.
- start while busy=1 is ignored (no queueing).
- States:
  - IDLE: both lines released; wait for an accepted start.
  - START (2 quarters): quarter 1 SCL/SDA released; quarter 2 SDA driven 0 with SCL high; exit with SCL driven low.
  - ADDR (8 bits): shift out {addr[6:0], rw}, MSB first.
  - ADDR_ACK (1 bit): SDA released; sampled 1 -> ack_err=1, go to STOP. Sampled 0 -> WRITE if rw=0, else READ.
  - WRITE (8 bits): shift out wr_data, MSB first.
  - WRITE_ACK (1 bit): SDA released; sampled 1 -> ack_err=1. Then STOP.
  - READ (8 bits): SDA released; shift sampled bits into rd_data, MSB first.
  - READ_NACK (1 bit): master releases SDA (NACK, last byte). Then STOP.
  - STOP (3 quarters): SCL low with SDA driven 0; release SCL; release SDA. Then done=1 for one clk, busy=0, go to IDLE.
- Latency in quarters, START through STOP end:
  - full write or read: 2 + 72 + 3 = 77, i.e. 77*CLK_DIV clks with no stretching.
  - address NACK: 2 + 36 + 3 = 41.
- rd_data updates only in READ and holds until the next read transaction. It is not cleared on a write.
- SDA transitions occur only while SCL is low, except the START/STOP edges.
- No arbitration detection; single-master bus only.

Decomposition:
- Shared package i2c_pkg:
  - state enum (IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_NACK, STOP)
  - quarter-phase constants Q0..Q3
  - bits-per-byte constant 8
  - ACK=0 / NACK=1 constants
- Sub-module: i2c_tick_gen, the CLK_DIV prescaler with enable, restart and hold (stretch) inputs and a qtick output.

Test Plan:
- Write, CLK_DIV=4: ACKing slave model at 0x48, start with rw=0, addr=0x48, wr_data=0xA5 -> bus shows START, byte 0x90, ACK, byte 0xA5, ACK, STOP. done pulses at 77*4 clks after busy rises; ack_err=0.
- Read: slave at 0x48 returns 0x3C, start with rw=1 -> address byte 0x91, master releases SDA at bit 9 (NACK), STOP. rd_data=0x3C at done; ack_err=0.
- Address NACK: no slave responds, addr=0x22 -> STOP follows the address ACK slot with no data phase. done at 41*4 clks; ack_err=1.
- Clock stretch: slave holds SCL low 37 clks during the Q1 of address bit 3 -> done is delayed by exactly 37 clks; all bit values are unchanged.
- Reset mid-byte: assert reset during WRITE bit 4 -> scl and sda go Z within the same cycle; busy=0; a following write of 0x5A completes correctly.
- Busy collision: second start pulse issued during ADDR -> ignored; exactly one done pulse; latched addr and data are unchanged.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bit-level constants for the I2C master
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_NACK, STOP
  } state_t;
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;
  localparam int BITS = 8;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_tick_gen.sv
// i2c_tick_gen: quarter-bit prescaler with restart and clock-stretch hold
module i2c_tick_gen #(
  parameter int CLK_DIV = 125
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  input  logic hold,
  output logic qtick
);
  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);
  logic [15:0] cnt_q, cnt_d;
  assign qtick = en && !hold && !restart && cnt_q == LAST;
  // Count while enabled, freeze on hold, wrap to zero at each quarter boundary
  always_comb begin
    cnt_d = restart ? '0 : (!en || hold) ? cnt_q : qtick ? '0 : cnt_q + 16'd1;
  end
  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/i2c_master_fsm.sv
// i2c_master_fsm: single-byte I2C master (START, addr+R/W, one data byte, STOP)
module i2c_master_fsm
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] slave_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  inout  wire        scl,
  inout  wire        sda
);
  state_t state_q, state_d;
  logic [1:0] qtr_q, qtr_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, wdata_q, wdata_d, rd_q, rd_d;
  logic rw_q, rw_d, ack_err_q, ack_err_d, done_q, done_d;
  logic accept, qtick, hold, in_bit, last_bit, tx_bit, scl_low, sda_low, scl_in, sda_in;

  assign scl_in = scl;
  assign sda_in = sda;
  assign scl = scl_low ? 1'b0 : 1'bz;
  assign sda = sda_low ? 1'b0 : 1'bz;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign ack_err = ack_err_q;
  assign rd_data = rd_q;
  assign accept = start && !busy;
  assign in_bit = state_q inside {ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_NACK};
  assign last_bit = bit_q == 3'(BITS - 1);
  // A slave holding SCL low after we release it in Q1 freezes the quarter timer
  assign hold = qtr_q == Q1 && !scl_low && !scl_in;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .en(busy),
    .restart(accept),
    .hold(hold),
    .qtick(qtick)
  );

  // Pin drive decoded from the registered state so reset releases the bus at once
  always_comb begin
    tx_bit = (state_q == ADDR || state_q == WRITE) ? shift_q[7] : NACK;
    scl_low = in_bit ? (qtr_q == Q0 || qtr_q == Q3) : (state_q == STOP && qtr_q == Q0);
    sda_low = in_bit ? tx_bit == ACK :
              state_q == START ? qtr_q == Q1 :
              state_q == STOP && qtr_q != Q2;
  end

  // Next-state: quarter/bit sequencing, SDA sampling at the end of Q2
  always_comb begin
    state_d = state_q;
    qtr_d = qtr_q;
    bit_d = bit_q;
    shift_d = shift_q;
    wdata_d = wdata_q;
    rw_d = rw_q;
    rd_d = rd_q;
    ack_err_d = ack_err_q;
    done_d = 1'b0;
    if (accept) begin
      state_d = START;
      qtr_d = Q0;
      bit_d = '0;
      shift_d = {slave_addr, rw};
      wdata_d = wr_data;
      rw_d = rw;
      ack_err_d = 1'b0;
    end else if (qtick) begin
      qtr_d = qtr_q + 2'd1;
      if (qtr_q == Q2 && state_q == READ) rd_d = {rd_q[6:0], sda_in};
      if (qtr_q == Q2 && (state_q == ADDR_ACK || state_q == WRITE_ACK)) ack_err_d = sda_in == NACK;
      if (state_q == START && qtr_q == Q1) begin
        state_d = ADDR;
        qtr_d = Q0;
      end
      if (state_q == STOP && qtr_q == Q2) begin
        state_d = IDLE;
        qtr_d = Q0;
        done_d = 1'b1;
      end
      if (qtr_q == Q3) begin
        case (state_q)
          ADDR: begin
            shift_d = shift_q << 1;
            bit_d = bit_q + 3'd1;
            state_d = last_bit ? ADDR_ACK : ADDR;
          end
          ADDR_ACK: begin
            shift_d = wdata_q;
            state_d = ack_err_q ? STOP : rw_q ? READ : WRITE;
          end
          WRITE: begin
            shift_d = shift_q << 1;
            bit_d = bit_q + 3'd1;
            state_d = last_bit ? WRITE_ACK : WRITE;
          end
          READ: begin
            bit_d = bit_q + 3'd1;
            state_d = last_bit ? READ_NACK : READ;
          end
          WRITE_ACK, READ_NACK: state_d = STOP;
          default: ;
        endcase
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      qtr_q <= Q0;
      bit_q <= '0;
      shift_q <= '0;
      wdata_q <= '0;
      rw_q <= 1'b0;
      rd_q <= '0;
      ack_err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      qtr_q <= qtr_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      wdata_q <= wdata_d;
      rw_q <= rw_d;
      rd_q <= rd_d;
      ack_err_q <= ack_err_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_i2c_master_fsm.sv
// tb_i2c_master_fsm: bus-level slave model and transaction checks for i2c_master_fsm
module tb_i2c_master_fsm;
  localparam int CD = 4;
  localparam logic [6:0] SLV = 7'h48;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, rw = 1'b0;
  logic [6:0] slave_addr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic busy, done, ack_err;
  wire scl, sda;
  logic scl_slv = 1'b1, sda_slv = 1'b1;
  int cyc = 0, n_assert = 0, n_fail = 0;
  int starts = 0, stops = 0, nrise = 0, done_cnt = 0, busy_cyc = 0, done_cyc = 0, stretch_len = 0;
  logic [31:0] cap = '0;
  logic pscl = 1'b1, psda = 1'b1, pbusy = 1'b0, matched = 1'b0, rd_mode = 1'b0;
  logic [7:0] slv_rd = '0, slv_wr = '0, rd_exp = '0;

  pullup (scl);
  pullup (sda);
  assign scl = scl_slv ? 1'bz : 1'b0;
  assign sda = sda_slv ? 1'bz : 1'b0;

  i2c_master_fsm #(.CLK_DIV(CD)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .rw(rw),
    .slave_addr(slave_addr),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .busy(busy),
    .done(done),
    .ack_err(ack_err),
    .scl(scl),
    .sda(sda)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor and slave at 0x48: sees the pins on the falling clk edge, changes SDA only after SCL falls
  initial forever begin
    @(negedge clk);
    if (busy && !pbusy) busy_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (pscl && scl && psda && !sda) begin
      starts++;
      nrise = 0;
      matched = 1'b0;
    end
    if (pscl && scl && !psda && sda) stops++;
    if (!pscl && scl) begin
      cap = {cap[30:0], sda};
      nrise++;
    end
    if (pscl && !scl) begin
      if (nrise == 8) begin
        matched = cap[7:1] == SLV;
        rd_mode = cap[0];
      end
      if (matched && !rd_mode && nrise == 17) slv_wr = cap[7:0];
      sda_slv = !(matched && (nrise == 8 ||
                (rd_mode ? (nrise >= 9 && nrise <= 16 && !slv_rd[3'(16 - nrise)]) : nrise == 17)));
    end
    if (stretch_len > 0 && cyc == busy_cyc + 15 * CD - 1) scl_slv = 1'b0;
    if (!scl_slv && cyc == busy_cyc + 15 * CD + stretch_len) scl_slv = 1'b1;
    pscl = scl;
    psda = sda;
    pbusy = busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic r, input logic [6:0] a, input logic [7:0] d, input logic [7:0] rb,
                     input int stretch, input bit collide);
    int d0, s0, p0;
    logic present;
    logic [31:0] c;
    present = a == SLV;
    d0 = done_cnt;
    s0 = starts;
    p0 = stops;
    slv_rd = rb;
    stretch_len = stretch;
    @(negedge clk);
    rw = r;
    slave_addr = a;
    wr_data = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_on_accept", busy, 1);
    if (collide) begin
      repeat (10 * CD) @(negedge clk);
      rw = ~r;
      slave_addr = ~a;
      wr_data = ~d;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 400 * CD && done_cnt == d0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    stretch_len = 0;
    check("done_pulses", done_cnt - d0, 1);
    check("latency", done_cyc - busy_cyc, (present ? 77 : 41) * CD + stretch);
    check("ack_err", ack_err, !present);
    check("scl_rises", nrise, present ? 19 : 10);
    c = cap >> 1;
    check("addr_byte", present ? c[17:10] : c[8:1], {a, r});
    check("addr_ack_slot", present ? c[9] : c[0], !present);
    if (present) begin
      check("data_byte", c[8:1], r ? rb : d);
      check("last_slot", c[0], r);
      if (r) rd_exp = rb;
      else check("slave_got", slv_wr, d);
    end
    check("rd_data", rd_data, rd_exp);
    check("start_count", starts - s0, 1);
    check("stop_count", stops - p0, 1);
    check("busy_off", busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);
    reset = 1'b0;
    txn(1'b0, SLV, 8'hA5, 8'h00, 0, 1'b0);
    txn(1'b1, SLV, 8'h00, 8'h3C, 0, 1'b0);
    txn(1'b0, 7'h22, 8'h77, 8'h00, 0, 1'b0);
    txn(1'b1, 7'h22, 8'h00, 8'hEE, 0, 1'b0);
    txn(1'b0, SLV, 8'hC3, 8'h00, 37, 1'b0);
    txn(1'b0, SLV, 8'h33, 8'h00, 0, 1'b1);
    @(negedge clk);
    rw = 1'b0;
    slave_addr = SLV;
    wr_data = 8'hA5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (56 * CD + 1) @(negedge clk);
    check("mid_scl_high", scl, 1);
    check("mid_sda_low", sda, 0);
    reset = 1'b1;
    #1;
    check("rst_mid_scl", scl, 1);
    check("rst_mid_sda", sda, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rd_data", rd_data, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    rd_exp = 8'h00;
    txn(1'b0, SLV, 8'h5A, 8'h00, 0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      logic [6:0] a;
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLV;
      txn(1'($urandom_range(0, 1)), a, 8'($urandom), 8'($urandom), 0, 1'b0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
